// File: rtl/ahb_master.sv
// AHB-Lite initiator: issues pipelined NONSEQ SINGLE transfers from a command stream.
// Optional wait-state timeout flag is compiled in with `define AHB_MASTER_TIMEOUT_EN.
module ahb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              timeout_o
);

  logic              r_aValid;
  logic [ADDR_W-1:0] r_aAddr;
  logic              r_aWrite;
  logic [1:0]        r_aSize;
  logic [DATA_W-1:0] r_aWdata;
  logic              r_dValid;
  logic              r_dWrite;
  logic [DATA_W-1:0] r_dWdata;
  logic              r_err2;

  logic              w_err1;
  logic              w_mask;
  logic              w_aAdvance;
  logic              w_dDone;
  logic              w_accept;
  logic [1:0]        w_cmdSize;

  // The address phase is masked for both ERROR cycles so the pending transfer is replayed afterwards.
  assign w_err1     = r_dValid && HRESP && !HREADY;
  assign w_mask     = w_err1 || r_err2;
  assign w_aAdvance = HREADY && r_aValid && !w_mask;
  assign w_dDone    = HREADY && r_dValid;
  assign cmd_ready  = (!r_aValid || (HREADY && !w_mask)) && !w_err1;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_cmdSize  = (cmd_size == 2'b11) ? 2'b10 : cmd_size;

  assign HTRANS = (r_aValid && !w_mask) ? 2'b10 : 2'b00;
  assign HADDR  = r_aAddr;
  assign HWRITE = r_aWrite;
  assign HSIZE  = {1'b0, r_aSize};
  assign HBURST = 3'b000;
  assign HWDATA = r_dWdata;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_aValid <= 1'b0;
      r_aAddr  <= '0;
      r_aWrite <= 1'b0;
      r_aSize  <= 2'b10;
      r_aWdata <= '0;
    end else if (w_accept) begin
      r_aValid <= 1'b1;
      r_aAddr  <= cmd_addr;
      r_aWrite <= cmd_write;
      r_aSize  <= w_cmdSize;
      r_aWdata <= cmd_wdata;
    end else if (w_aAdvance) begin
      r_aValid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dValid <= 1'b0;
      r_dWrite <= 1'b0;
      r_dWdata <= '0;
    end else if (w_aAdvance) begin
      r_dValid <= 1'b1;
      r_dWrite <= r_aWrite;
      r_dWdata <= r_aWdata;
    end else if (w_dDone) begin
      r_dValid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_err2    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_err2    <= w_err1;
      rsp_valid <= w_dDone;
      rsp_err   <= w_dDone && HRESP;
      rsp_rdata <= (w_dDone && !r_dWrite) ? HRDATA : '0;
    end
  end

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_waitCnt;
  logic             r_timeout;

  // Flag only; the stalled transfer is left on the bus and keeps waiting.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_waitCnt <= '0;
      r_timeout <= 1'b0;
    end else if (r_dValid && !HREADY) begin
      if (r_waitCnt != CNT_W'(TIMEOUT_CYCLES)) r_waitCnt <= r_waitCnt + CNT_W'(1);
      if (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
    end else begin
      r_waitCnt <= '0;
    end
  end

  assign timeout_o = r_timeout;
`else
  // Always 0; the compare keeps the parameter referenced when the feature is absent.
  assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ahb_master.sv
// Randomized self-checking bench for ahb_master with a transaction-level slave and scoreboard.
// Timeout checks are active when AHB_MASTER_TIMEOUT_EN is defined.
module tb_ahb_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        timeout_o;

  ahb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .timeout_o(timeout_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          acceptCycle;
  } cmd_t;

  typedef struct {
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } scfg_t;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int expLatency = -1;

  cmd_t  cmdQ[$];
  cmd_t  dirQ[$];
  scfg_t cfgQ[$];
  cmd_t  genCmd;
  bit    genHas;
  bit    randomCmds;

  bit          spActive;
  cmd_t        spCmd;
  int          spWaits;
  bit          spErr;
  int          spErrStage;
  logic [31:0] spRdata;

  bit          rspDue;
  bit          rspErrExp;
  logic [31:0] rspDataExp;
  int          rspAccept;

  logic [31:0] lastAddr;
  logic        lastWrite;
  logic [2:0]  lastSize;
  bit          timeoutExp;
`ifdef AHB_MASTER_TIMEOUT_EN
  int          waitRun;
`endif

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [2:0] normSize(input logic [1:0] s);
    return (s == 2'd3) ? 3'd2 : {1'b0, s};
  endfunction

  function automatic cmd_t makeCmd(input logic write, input logic [31:0] addr,
                                   input logic [1:0] size, input logic [31:0] wdata);
    cmd_t c;
    c.addr = addr; c.write = write; c.size = size; c.wdata = wdata; c.acceptCycle = 0;
    return c;
  endfunction

  function automatic scfg_t makeCfg(input int waits, input bit err, input logic [31:0] rdata);
    scfg_t s;
    s.waits = waits; s.err = err; s.rdata = rdata;
    return s;
  endfunction

  // One bus cycle: drive both sides, check outputs against the model, then advance the model.
  task automatic applyStimulus();
    cmd_t  c;
    scfg_t s;
    bit    inErr;
    bit    expReady;
    @(negedge HCLK);
    if (!genHas) begin
      if (dirQ.size() > 0) begin
        genCmd = dirQ.pop_front();
        genHas = 1'b1;
      end else if (randomCmds && $urandom_range(99) < 80) begin
        genCmd = makeCmd(1'($urandom_range(1)), $urandom(), 2'($urandom_range(3)), $urandom());
        genHas = 1'b1;
      end
    end
    cmd_valid = genHas;
    cmd_write = genHas ? genCmd.write : 1'($urandom_range(1));
    cmd_addr  = genHas ? genCmd.addr  : $urandom();
    cmd_size  = genHas ? genCmd.size  : 2'($urandom_range(3));
    cmd_wdata = genHas ? genCmd.wdata : $urandom();

    inErr = spActive && spErr && (spWaits == 0);
    if (spActive && spWaits > 0) begin
      HREADY = 1'b0; HRESP = 1'b0;
    end else if (inErr) begin
      HREADY = (spErrStage == 1); HRESP = 1'b1;
    end else begin
      HREADY = 1'b1; HRESP = 1'b0;
    end
    HRDATA = (spActive && !spCmd.write) ? spRdata : $urandom();
    #1;
    cycle++;

    checkOutput("rspValid", rsp_valid, rspDue);
    if (rspDue && rsp_valid) begin
      checkOutput("rspErr", rsp_err, rspErrExp);
      checkOutput("rspRdata", rsp_rdata, rspDataExp);
      if (expLatency > 0) checkOutput("latency", cycle - rspAccept, expLatency);
    end
    rspDue = 1'b0;

    expReady = (cmdQ.size() == 0 || (HREADY && !inErr)) && !(inErr && !HREADY);
    checkOutput("cmdReady", cmd_ready, expReady);
    checkOutput("htrans", HTRANS, (cmdQ.size() > 0 && !inErr) ? 2'b10 : 2'b00);
    if (cmdQ.size() > 0) begin
      lastAddr  = cmdQ[0].addr;
      lastWrite = cmdQ[0].write;
      lastSize  = normSize(cmdQ[0].size);
    end
    checkOutput("haddr", HADDR, lastAddr);
    checkOutput("hwrite", HWRITE, lastWrite);
    checkOutput("hsize", HSIZE, lastSize);
    checkOutput("hburst", HBURST, 3'b000);
    checkOutput("timeout", timeout_o, timeoutExp);

`ifdef AHB_MASTER_TIMEOUT_EN
    if (spActive && !HREADY) waitRun++;
    else waitRun = 0;
    if (waitRun >= 16) timeoutExp = 1'b1;
`endif

    if (spActive && HREADY) begin
      if (spCmd.write) checkOutput("hwdata", HWDATA, spCmd.wdata);
      rspDue     = 1'b1;
      rspErrExp  = spErr;
      rspDataExp = spCmd.write ? 32'h0 : spRdata;
      rspAccept  = spCmd.acceptCycle;
      spActive   = 1'b0;
    end else if (spActive) begin
      if (spWaits > 0) spWaits--;
      else spErrStage++;
    end

    if (HTRANS == 2'b10 && HREADY) begin
      if (cmdQ.size() == 0) begin
        checkOutput("unexpectedTransfer", 1, 0);
      end else begin
        c = cmdQ.pop_front();
        if (cfgQ.size() > 0) s = cfgQ.pop_front();
        else s = makeCfg(($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0,
                         ($urandom_range(9) == 0), $urandom());
        spActive   = 1'b1;
        spCmd      = c;
        spWaits    = s.waits;
        spErr      = s.err;
        spErrStage = 0;
        spRdata    = s.rdata;
      end
    end

    if (cmd_valid && cmd_ready) begin
      genCmd.acceptCycle = cycle;
      cmdQ.push_back(genCmd);
      genHas = 1'b0;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic resetDut(input bit doCheck);
    @(negedge HCLK);
    HRESETn = 1'b0; cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK);
    #1;
    if (doCheck) begin
      checkOutput("resetHtrans", HTRANS, 2'b00);
      checkOutput("resetHaddr", HADDR, 32'h0);
      checkOutput("resetHwrite", HWRITE, 1'b0);
      checkOutput("resetHsize", HSIZE, 3'b010);
      checkOutput("resetHwdata", HWDATA, 32'h0);
      checkOutput("resetRspValid", rsp_valid, 1'b0);
      checkOutput("resetRspRdata", rsp_rdata, 32'h0);
      checkOutput("resetRspErr", rsp_err, 1'b0);
      checkOutput("resetTimeout", timeout_o, 1'b0);
      checkOutput("resetCmdReady", cmd_ready, 1'b1);
    end
    cmdQ.delete();
    genHas = 1'b0; spActive = 1'b0; rspDue = 1'b0;
    lastAddr = 32'h0; lastWrite = 1'b0; lastSize = 3'b010; timeoutExp = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
    waitRun = 0;
`endif
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    int guard;
    bit busy;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0; randomCmds = 1'b0;
    resetDut(1'b1);

    $display("[TB] single read, zero wait");
    expLatency = 3;
    cfgQ.push_back(makeCfg(0, 1'b0, 32'hDEAD_BEEF));
    dirQ.push_back(makeCmd(1'b0, 32'h0000_1000, 2'd2, 32'h0));
    runCycles(6);

    $display("[TB] four back-to-back writes");
    for (int i = 0; i < 4; i++) begin
      cfgQ.push_back(makeCfg(0, 1'b0, 32'h0));
      dirQ.push_back(makeCmd(1'b1, 32'(i * 4), 2'd2, 32'(i + 1)));
    end
    runCycles(8);

    $display("[TB] read with three wait states, next command pending");
    expLatency = 6;
    cfgQ.push_back(makeCfg(3, 1'b0, 32'h1234_5678));
    cfgQ.push_back(makeCfg(0, 1'b0, 32'h8765_4321));
    dirQ.push_back(makeCmd(1'b0, 32'h0000_2000, 2'd2, 32'h0));
    dirQ.push_back(makeCmd(1'b0, 32'h0000_2004, 2'd1, 32'h0));
    runCycles(12);

    $display("[TB] ERROR response with replay");
    expLatency = -1;
    cfgQ.push_back(makeCfg(0, 1'b1, 32'h0));
    cfgQ.push_back(makeCfg(0, 1'b0, 32'hCAFE_F00D));
    dirQ.push_back(makeCmd(1'b1, 32'h0000_0100, 2'd2, 32'hA5A5_0001));
    dirQ.push_back(makeCmd(1'b0, 32'h0000_0104, 2'd2, 32'h0));
    runCycles(10);

    $display("[TB] reset during wait state");
    cfgQ.push_back(makeCfg(6, 1'b0, 32'h5555_AAAA));
    dirQ.push_back(makeCmd(1'b0, 32'h0000_0200, 2'd2, 32'h0));
    runCycles(4);
    resetDut(1'b1);
    runCycles(6);

`ifdef AHB_MASTER_TIMEOUT_EN
    $display("[TB] wait-state timeout");
    cfgQ.push_back(makeCfg(20, 1'b0, 32'h0BAD_CAFE));
    dirQ.push_back(makeCmd(1'b0, 32'h0000_0300, 2'd2, 32'h0));
    runCycles(30);
    checkOutput("timeoutSticky", timeout_o, 1'b1);
    resetDut(1'b1);
`endif

    $display("[TB] randomized traffic");
    randomCmds = 1'b1;
    runCycles(3000);
    randomCmds = 1'b0;
    guard = 0;
    busy = genHas || (cmdQ.size() > 0) || spActive || rspDue;
    while (busy && guard < 200) begin
      applyStimulus();
      guard++;
      busy = genHas || (cmdQ.size() > 0) || spActive || rspDue;
    end
    checkOutput("drainDone", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
